// File: rtl/usb_fs_tx.sv
// ---------------------------------------------------------------------------
// usb_fs_tx -- full-speed USB transmit serializer.
//
// Takes a packet request from the protocol engines, then sends it on the
// wire with bit stuffing and NRZI encoding: SYNC, PID, optional payload with
// CRC16, and EOP. Each bit time lasts BIT_CLKS system clocks, so a 48 MHz
// clock gives 12 Mb/s.
//
// Parameters
//   BIT_CLKS       clocks per bit time (>= 3)
//
// Ports
//   clk            system clock (48 MHz)
//   reset_n        asynchronous active-low reset
//   tx_pkt_start   single-cycle request strobe; ignored while busy
//   tx_pid[3:0]    packet PID, sampled with tx_pkt_start
//   tx_data_avail  upstream holds another payload byte
//   tx_data_get    single-cycle pulse: byte on tx_data consumed
//   tx_data[7:0]   payload byte
//   tx_pkt_end     single-cycle pulse: packet done, line back to idle J
//   usb_tx_en      D+/D- driver output enable
//   usb_p_tx       D+ drive value
//   usb_n_tx       D- drive value
//   tx_busy        high from the cycle after acceptance through tx_pkt_end
//   debug[7:0]     only with USB_FS_TX_DEBUG_EN defined:
//                  {state, stuff count, tx_data_get, tx_pkt_end}
//
// Upstream byte handshake: the byte on tx_data is consumed at the bit
// boundary where the serializer needs a new byte and tx_data_avail is high.
// tx_data_get pulses in the next clock, which is also the first clock of that
// byte's first bit. tx_data_avail low at that boundary ends the payload.
// ---------------------------------------------------------------------------
module usb_fs_tx #(
  parameter int BIT_CLKS = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tx_pkt_start,
  input  logic [3:0] tx_pid,
  input  logic       tx_data_avail,
  output logic       tx_data_get,
  input  logic [7:0] tx_data,
  output logic       tx_pkt_end,
  output logic       usb_tx_en,
  output logic       usb_p_tx,
  output logic       usb_n_tx,
`ifdef USB_FS_TX_DEBUG_EN
  output logic [7:0] debug,
`endif
  output logic       tx_busy
);

  localparam int CW = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
  localparam logic [CW-1:0] LAST_CLK = CW'(BIT_CLKS - 1);
  localparam logic [7:0] SYNC_PAT = 8'h80;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SYNC    = 3'd1,
    S_PID     = 3'd2,
    S_DATA    = 3'd3,
    S_CRC     = 3'd4,
    S_EOP_SE0 = 3'd5,
    S_EOP_J   = 3'd6
  } state_t;

  // State and datapath registers.
  state_t        state_q, state_d;
  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic [3:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [15:0]   crc_q, crc_d;
  logic [2:0]    ones_q, ones_d;
  logic          line_q, line_d;
  logic          is_data_q, is_data_d;
  logic          en_q, en_d;
  logic          p_q, p_d;
  logic          n_q, n_d;
  logic          get_q, get_d;
  logic          end_q, end_d;

  // Per-boundary control produced by the next-state logic.
  logic          boundary;
  logic          send;
  logic          val;
  logic          counted;
  logic          crc_upd;
  logic          do_fetch;
  logic          stuff_field;
  logic [2:0]    ones_base;
  logic [3:0]    nxt_idx;

  // CRC16 (x^16+x^15+x^2+1) in reflected form: the register shifts right so
  // bit 0 is the next CRC bit to go on the wire, LSB first.
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    logic        fb;
    logic [15:0] r;
    fb = b ^ c[0];
    r  = {1'b0, c[15:1]};
    if (fb) r = r ^ 16'hA001;
    return r;
  endfunction

  assign boundary    = (clk_cnt_q == LAST_CLK);
  assign nxt_idx     = bit_idx_q + 4'd1;
  assign stuff_field = (state_q == S_PID) || (state_q == S_DATA) || (state_q == S_CRC);
  // The ones run restarts with the first PID bit; SYNC's trailing 1 does not count.
  assign ones_base   = (state_q == S_SYNC) ? 3'd0 : ones_q;

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    crc_d     = crc_q;
    ones_d    = ones_q;
    line_d    = line_q;
    is_data_d = is_data_q;
    en_d      = en_q;
    p_d       = p_q;
    n_d       = n_q;
    get_d     = 1'b0;
    end_d     = 1'b0;
    send      = 1'b0;
    val       = 1'b0;
    counted   = 1'b0;
    crc_upd   = 1'b0;
    do_fetch  = 1'b0;

    if (state_q == S_IDLE) begin
      clk_cnt_d = '0;
      // A start in the tx_pkt_end cycle is dropped.
      if (tx_pkt_start && !end_q) begin
        state_d   = S_SYNC;
        bit_idx_d = 4'd0;
        is_data_d = &tx_pid[1:0];
        shift_d   = {~tx_pid, tx_pid};
        crc_d     = 16'hFFFF;
        ones_d    = 3'd0;
        en_d      = 1'b1;
        send      = 1'b1;
        val       = SYNC_PAT[0];
      end
    end else begin
      clk_cnt_d = boundary ? '0 : clk_cnt_q + 1'b1;
      if (boundary) begin
        if (stuff_field && (ones_q == 3'd6)) begin
          // Stuff bit: field position is held, only the line toggles.
          send   = 1'b1;
          val    = 1'b0;
          ones_d = 3'd0;
        end else begin
          case (state_q)
            S_SYNC: begin
              send = 1'b1;
              if (bit_idx_q == 4'd7) begin
                state_d   = S_PID;
                bit_idx_d = 4'd0;
                val       = shift_q[0];
                counted   = 1'b1;
              end else begin
                bit_idx_d = nxt_idx;
                val       = SYNC_PAT[nxt_idx[2:0]];
              end
            end
            S_PID: begin
              if (bit_idx_q != 4'd7) begin
                bit_idx_d = nxt_idx;
                send      = 1'b1;
                val       = shift_q[nxt_idx[2:0]];
                counted   = 1'b1;
              end else if (is_data_q) begin
                do_fetch = 1'b1;
              end else begin
                state_d   = S_EOP_SE0;
                bit_idx_d = 4'd0;
                p_d       = 1'b0;
                n_d       = 1'b0;
              end
            end
            S_DATA: begin
              if (bit_idx_q != 4'd7) begin
                bit_idx_d = nxt_idx;
                send      = 1'b1;
                val       = shift_q[nxt_idx[2:0]];
                counted   = 1'b1;
                crc_upd   = 1'b1;
              end else begin
                do_fetch = 1'b1;
              end
            end
            S_CRC: begin
              // CRC register is frozen here and read out complemented.
              if (bit_idx_q != 4'd15) begin
                bit_idx_d = nxt_idx;
                send      = 1'b1;
                val       = ~crc_q[nxt_idx];
                counted   = 1'b1;
              end else begin
                state_d   = S_EOP_SE0;
                bit_idx_d = 4'd0;
                p_d       = 1'b0;
                n_d       = 1'b0;
              end
            end
            S_EOP_SE0: begin
              if (bit_idx_q == 4'd0) begin
                bit_idx_d = 4'd1;
              end else begin
                state_d = S_EOP_J;
                p_d     = 1'b1;
                n_d     = 1'b0;
              end
            end
            S_EOP_J: begin
              state_d = S_IDLE;
              en_d    = 1'b0;
              p_d     = 1'b1;
              n_d     = 1'b0;
              line_d  = 1'b1;
              end_d   = 1'b1;
            end
            default: begin
              state_d = S_IDLE;
            end
          endcase

          // Byte boundary after PID or a payload byte: next byte or CRC.
          if (do_fetch) begin
            bit_idx_d = 4'd0;
            send      = 1'b1;
            counted   = 1'b1;
            if (tx_data_avail) begin
              state_d = S_DATA;
              shift_d = tx_data;
              get_d   = 1'b1;
              val     = tx_data[0];
              crc_upd = 1'b1;
            end else begin
              state_d = S_CRC;
              val     = ~crc_q[0];
            end
          end
        end
      end
    end

    // NRZI: 0 toggles the line, 1 holds it.
    if (send) begin
      line_d = val ? line_q : ~line_q;
      p_d    = line_d;
      n_d    = ~line_d;
    end
    if (counted) ones_d = val ? (ones_base + 3'd1) : 3'd0;
    if (crc_upd) crc_d = crc_step(crc_q, val);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= 4'd0;
      shift_q   <= 8'h00;
      crc_q     <= 16'hFFFF;
      ones_q    <= 3'd0;
      line_q    <= 1'b1;
      is_data_q <= 1'b0;
      en_q      <= 1'b0;
      p_q       <= 1'b1;
      n_q       <= 1'b0;
      get_q     <= 1'b0;
      end_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      crc_q     <= crc_d;
      ones_q    <= ones_d;
      line_q    <= line_d;
      is_data_q <= is_data_d;
      en_q      <= en_d;
      p_q       <= p_d;
      n_q       <= n_d;
      get_q     <= get_d;
      end_q     <= end_d;
    end
  end

  assign usb_tx_en   = en_q;
  assign usb_p_tx    = p_q;
  assign usb_n_tx    = n_q;
  assign tx_data_get = get_q;
  assign tx_pkt_end  = end_q;
  // The tx_pkt_end cycle already has state IDLE but still counts as busy.
  assign tx_busy     = (state_q != S_IDLE) || end_q;

`ifdef USB_FS_TX_DEBUG_EN
  assign debug = {state_q, ones_q, get_q, end_q};
`endif

endmodule
